// File: rtl/fw_rv_buf_pkg.sv
// Occupancy encoding shared by the forward/skid buffer and its bench.
package fw_rv_buf_pkg;
  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;
endpackage

// File: rtl/fw_rv_buf_stage.sv
// WIDTH-bit load-enabled data register, async active-low reset to zero.
module fw_rv_buf_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_ld) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/fw_rv_buf.sv
// Two-entry forward/skid buffer for a valid/ready stream; all handshake outputs decode from state.
// Optional occupancy port o_count is enabled by defining FW_RV_BUF_COUNT_EN.
module fw_rv_buf
  import fw_rv_buf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_valid,
  input  logic             o_ready
`ifdef FW_RV_BUF_COUNT_EN
  ,output logic [1:0]      o_count
`endif
);
  occ_t             r_occ;
  occ_t             w_occ;
  occ_t             w_nxt;
  logic             w_acc;
  logic             w_dlv;
  logic             w_ld_main;
  logic             w_ld_skid;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  // The unused code 3 behaves as empty so a corrupted state self-heals.
  assign w_occ   = (r_occ == OCC_ONE || r_occ == OCC_FULL) ? r_occ : OCC_EMPTY;
  assign i_ready = (w_occ != OCC_FULL);
  assign o_valid = (w_occ != OCC_EMPTY);
  assign o_dat   = w_main_q;
  assign w_acc   = i_valid && i_ready;
  assign w_dlv   = o_valid && o_ready;

  always_comb begin
    w_nxt     = w_occ;
    w_ld_main = 1'b0;
    w_ld_skid = 1'b0;
    case (w_occ)
      OCC_EMPTY: begin
        if (w_acc) begin
          w_ld_main = 1'b1;
          w_nxt     = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (w_acc && w_dlv) begin
          w_ld_main = 1'b1;
        end else if (w_acc) begin
          w_ld_skid = 1'b1;
          w_nxt     = OCC_FULL;
        end else if (w_dlv) begin
          w_nxt     = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (w_dlv) begin
          w_ld_main = 1'b1;
          w_nxt     = OCC_ONE;
        end
      end
      default: w_nxt = OCC_EMPTY;
    endcase
  end

  // When full the main register refills from the skid, otherwise from the input.
  assign w_main_d = (w_occ == OCC_FULL) ? w_skid_q : i_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_occ <= OCC_EMPTY;
    else        r_occ <= w_nxt;
  end

  fw_rv_buf_stage #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ld  (w_ld_main),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  fw_rv_buf_stage #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ld  (w_ld_skid),
    .i_d   (i_dat),
    .o_q   (w_skid_q)
  );

`ifdef FW_RV_BUF_COUNT_EN
  assign o_count = r_occ;
`endif
endmodule

// File: tb/tb_fw_rv_buf.sv
// Bench for fw_rv_buf: vector table, hand sequences, and random traffic on 8- and 32-bit instances.
module tb_fw_rv_buf;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  d8 = '0, od8;
  logic        v8 = 1'b0, r8 = 1'b0, ov8, ir8;
  logic [31:0] d32 = '0, od32;
  logic        v32 = 1'b0, r32 = 1'b0, ov32, ir32;
`ifdef FW_RV_BUF_COUNT_EN
  logic [1:0]  cnt8, cnt32;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fw_rv_buf #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_dat(d8), .i_valid(v8), .i_ready(ir8),
    .o_dat(od8), .o_valid(ov8), .o_ready(r8)
`ifdef FW_RV_BUF_COUNT_EN
    , .o_count(cnt8)
`endif
  );

  fw_rv_buf #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .i_dat(d32), .i_valid(v32), .i_ready(ir32),
    .o_dat(od32), .o_valid(ov32), .o_ready(r32)
`ifdef FW_RV_BUF_COUNT_EN
    , .o_count(cnt32)
`endif
  );

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       eov;
    logic [7:0] eod;
    logic       eir;
    logic [1:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic iv, input logic [7:0] d, input logic ordy,
                     input logic eov, input logic [7:0] eod, input logic eir,
                     input logic [1:0] ecnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.eov = eov; v.eod = eod; v.eir = eir; v.ecnt = ecnt;
    tbl.push_back(v);
  endtask

  logic [7:0]  q8[$];
  logic [31:0] q32[$];

  initial begin
    int sent8, recv8, sent32, recv32, cyc;
    logic acc8, dlv8, acc32, dlv32;

    // Reset held, then first cycle after release
    #12;
    chk("rst_ov", 32'(ov8), 32'd0);
    chk("rst_ir", 32'(ir8), 32'd1);
    chk("rst_od", 32'(od8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ov", 32'(ov8), 32'd0);
    chk("post_rst_ir", 32'(ir8), 32'd1);
    chk("post_rst_od32", od32, 32'd0);
`ifdef FW_RV_BUF_COUNT_EN
    chk("post_rst_cnt", 32'(cnt8), 32'd0);
`endif

    // Backpressure: two absorbed, third held off, then ordered drain
    add(1, 8'hA1, 0, 1, 8'hA1, 1, 1);
    add(1, 8'hA2, 0, 1, 8'hA1, 0, 2);
    add(1, 8'hA3, 0, 1, 8'hA1, 0, 2);
    add(1, 8'hA3, 1, 1, 8'hA2, 1, 1);
    add(1, 8'hA3, 1, 1, 8'hA3, 1, 1);
    add(0, 8'h00, 1, 0, 8'h00, 1, 0);
    // Stall stability while i_dat wanders
    add(1, 8'h5C, 0, 1, 8'h5C, 1, 1);
    for (int k = 0; k < 10; k++) add(0, 8'(k * 17 + 3), 0, 1, 8'h5C, 1, 1);
    add(1, 8'h77, 0, 1, 8'h5C, 0, 2);
    add(1, 8'h88, 0, 1, 8'h5C, 0, 2);
    add(0, 8'h00, 1, 1, 8'h77, 1, 1);
    add(0, 8'h00, 1, 0, 8'h00, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      v8 = tbl[i].iv; d8 = tbl[i].d; r8 = tbl[i].ordy;
      tick();
      chk($sformatf("tbl%0d_ov", i), 32'(ov8), 32'(tbl[i].eov));
      if (tbl[i].eov) chk($sformatf("tbl%0d_od", i), 32'(od8), 32'(tbl[i].eod));
      chk($sformatf("tbl%0d_ir", i), 32'(ir8), 32'(tbl[i].eir));
`ifdef FW_RV_BUF_COUNT_EN
      chk($sformatf("tbl%0d_cnt", i), 32'(cnt8), 32'(tbl[i].ecnt));
`endif
    end

    // Streaming at full rate
    r8 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      v8 = 1'b1; d8 = 8'(i);
      tick();
      chk("stream_ov", 32'(ov8), 32'd1);
      chk("stream_od", 32'(od8), 32'(i));
      chk("stream_ir", 32'(ir8), 32'd1);
    end
    v8 = 1'b0;
    tick();
    chk("stream_end_ov", 32'(ov8), 32'd0);

    // Asynchronous reset while full
    r8 = 1'b0; v8 = 1'b1; d8 = 8'h11;
    tick();
    d8 = 8'h22;
    tick();
    v8 = 1'b0;
    chk("full_ir", 32'(ir8), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_ov", 32'(ov8), 32'd0);
    chk("async_rst_ir", 32'(ir8), 32'd1);
    chk("async_rst_od", 32'(od8), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    r8 = 1'b1;
    tick();
    chk("after_rst_ov", 32'(ov8), 32'd0);
    chk("after_rst_ir", 32'(ir8), 32'd1);
    v8 = 1'b1; d8 = 8'h33;
    tick();
    chk("after_rst_od", 32'(od8), 32'h33);
    v8 = 1'b0;
    tick();
    chk("after_rst_drain", 32'(ov8), 32'd0);

    // Random traffic against a two-deep FIFO model
    sent8 = 0; recv8 = 0; sent32 = 0; recv32 = 0; cyc = 0;
    while ((recv8 < 1000 || recv32 < 1000) && cyc < 20000) begin
      chk("rnd8_ov", 32'(ov8), 32'(q8.size() != 0));
      chk("rnd8_ir", 32'(ir8), 32'(q8.size() < 2));
      if (q8.size() != 0) chk("rnd8_od", 32'(od8), 32'(q8[0]));
      chk("rnd32_ov", 32'(ov32), 32'(q32.size() != 0));
      chk("rnd32_ir", 32'(ir32), 32'(q32.size() < 2));
      if (q32.size() != 0) chk("rnd32_od", od32, q32[0]);

      v8  = (sent8 < 1000) && ($urandom_range(0, 3) != 0);
      d8  = 8'($urandom);
      r8  = ($urandom_range(0, 3) != 0);
      v32 = (sent32 < 1000) && ($urandom_range(0, 2) != 0);
      d32 = $urandom;
      r32 = ($urandom_range(0, 2) != 0);
      acc8  = v8 && (q8.size() < 2);
      dlv8  = r8 && (q8.size() != 0);
      acc32 = v32 && (q32.size() < 2);
      dlv32 = r32 && (q32.size() != 0);
      tick();
      if (dlv8)  begin void'(q8.pop_front());  recv8++;  end
      if (acc8)  begin q8.push_back(d8);       sent8++;  end
      if (dlv32) begin void'(q32.pop_front()); recv32++; end
      if (acc32) begin q32.push_back(d32);     sent32++; end
      cyc++;
    end
    chk("rnd8_words", 32'(recv8), 32'd1000);
    chk("rnd32_words", 32'(recv32), 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fw_rv_buf.md
# fw_rv_buf

Two-entry forward/skid buffer for a valid/ready byte stream, parameterized in data width. Sits between a producer and a consumer on any point-to-point valid/ready link (e.g. endpoint network-in to network-out and to TIP paths) and breaks every combinational path between the two sides. It preserves ordering and sustains one transfer per cycle.

## Interface
- WIDTH, default 8: data width in bits.
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- i_dat  in  WIDTH  input data.
- i_valid  in  1  input data valid.
- i_ready  out  1  buffer can accept; input transfer when i_valid && i_ready at rising edge.
- o_dat  out  WIDTH  output data.
- o_valid  out  1  output data valid.
- o_ready  in  1  consumer accepts; output transfer when o_valid && o_ready at rising edge.
- count  out  2  occupancy, only present with FW_RV_BUF_COUNT_EN.

## Operation
- Storage: main register (drives o_dat/o_valid) and skid register. Occupancy N ∈ {0,1,2}.
- i_ready = (N != 2), decoded only from state; o_valid = (N != 0); o_dat = main register.
- acc = i_valid && i_ready; dlv = o_valid && o_ready.
- N=0: acc → main ← i_dat, N=1. No acc → hold.
- N=1: acc && dlv → main ← i_dat, N=1. acc only → skid ← i_dat, N=2. dlv only → N=0. Neither → hold.
- N=2: dlv → main ← skid, N=1. No acc possible (i_ready=0). No dlv → hold.
- Never N=3; encoding beyond 2 is unreachable and treated as 0 after reset.
- Data is never dropped, duplicated or reordered.
- o_dat stable and o_valid held while o_valid && !o_ready.
- i_dat ignored when no acc; i_valid may deassert without handshake.
- Reset: o_valid=0, i_ready=1, o_dat=0, skid=0, N=0, count=0. Reset assertion mid-packet discards all stored data immediately, without waiting for a clock.

## Timing
- Latency: a word accepted at edge k is on o_dat with o_valid=1 after edge k (visible in cycle k+1).
- Throughput: one word per cycle sustained with o_ready held 1 (N stays 1).
- Backpressure: after o_ready drops, buffer absorbs one more word; i_ready falls the cycle after N reaches 2. It rises the cycle after the next dlv.
- No combinational path i_valid/i_dat → o_*, nor o_ready → i_ready.
- First cycle after reset deassertion: i_ready=1, o_valid=0.

## Configuration
- FW_RV_BUF_COUNT_EN defined: output port count present, equal to N (0..2), registered, reset 0.
- Not defined: port count absent; datapath behavior identical.

## Structure
- Package fw_rv_buf_pkg: occupancy constants OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_FULL=2'd2, and occupancy typedef.
- One sub-module natural: fw_rv_buf_stage, a WIDTH-bit load-enabled register with async active-low reset to 0. It is instantiated twice (main, skid).

## Test plan
- Reset: hold reset=0, then release → o_valid=0, i_ready=1, o_dat=0, count=0.
- Streaming: o_ready=1, present 0x01..0x10 one per cycle → identical sequence on o_dat, one cycle delayed, no bubbles, i_ready constantly 1.
- Backpressure: o_ready=0, offer 0xA1,0xA2,0xA3 → 0xA1,0xA2 accepted, i_ready=0, count=2. Set o_ready=1 → outputs 0xA1, 0xA2, 0xA3 in order.
- Stall stability: o_ready=0 with 0x5C held → o_dat=0x5C and o_valid=1 for 10 cycles. The word is not lost when i_dat changes.
- Random valid/ready toggling, 1000 words, WIDTH=8 and WIDTH=32 → scoreboard exact order, no loss or duplication.
- Reset mid-operation: N=2 holding 0x11,0x22, pull reset=0 between edges → o_valid=0 and i_ready=1 immediately. After release, no stale data appears.
